// File: rtl/muldiv_ctrl_if.sv
// Handshake and data bus between CtrlUnit (master) and the MULT/DIV engine (slave).
// Optional feature macro: MULDIV_ABORT_EN adds the abort request line.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             mult_start;
  logic             div_start;
`ifdef MULDIV_ABORT_EN
  logic             abort;
`endif
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             hi_write;
  logic             lo_write;

`ifdef MULDIV_ABORT_EN
  modport master (
    output mult_start, div_start, abort, op_a, op_b,
    input  busy, done, div_zero, hi_out, lo_out, hi_write, lo_write
  );
  modport slave (
    input  mult_start, div_start, abort, op_a, op_b,
    output busy, done, div_zero, hi_out, lo_out, hi_write, lo_write
  );
`else
  modport master (
    output mult_start, div_start, op_a, op_b,
    input  busy, done, div_zero, hi_out, lo_out, hi_write, lo_write
  );
  modport slave (
    input  mult_start, div_start, op_a, op_b,
    output busy, done, div_zero, hi_out, lo_out, hi_write, lo_write
  );
`endif
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle signed MULT/DIV engine and sequencer for the multicycle MIPS CPU.
// Radix-2 Booth multiply and restoring divide on magnitudes, one bit per cycle.
// Optional feature macro: MULDIV_ABORT_EN lets CtrlUnit flush a running operation.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for mult_start / div_start
// MULT   | Booth iteration, WIDTH cycles
// DIV    | restoring division iteration, WIDTH cycles
// DONE   | one cycle: results registered, HI/LO write strobes high
// DZERO  | one cycle: divisor was zero, done + div_zero, no HI/LO write
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clock,
  input  logic           reset,
  muldiv_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_DONE,
    S_DZERO
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             abort_req;

  // Booth: sign-extended upper half (WIDTH+1), lower half (WIDTH) and the
  // appended q(-1) bit together form the 2*WIDTH+1-bit accumulator. The extra
  // upper bit keeps A-M exact when M is the most negative value.
  logic [WIDTH:0]   b_acc;
  logic [WIDTH-1:0] b_q;
  logic             b_qm1;
  logic [WIDTH-1:0] b_m;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   b_sum;
  logic [WIDTH:0]   b_acc_nxt;
  logic [WIDTH-1:0] b_q_nxt;

  // Restoring divider on magnitudes; signs reapplied on the final step.
  logic [WIDTH-1:0] d_rem;
  logic [WIDTH-1:0] d_quo;
  logic [WIDTH-1:0] d_dvs;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH:0]   d_shift;
  logic [WIDTH-1:0] d_diff;
  logic             d_qbit;
  logic [WIDTH-1:0] d_rem_nxt;
  logic [WIDTH-1:0] d_quo_nxt;
  logic [WIDTH-1:0] d_quo_fix;
  logic [WIDTH-1:0] d_rem_fix;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_is_zero;

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

`ifdef MULDIV_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  assign cnt_last  = (cnt == '0);
  assign a_mag     = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
  assign b_mag     = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
  assign b_is_zero = (bus.op_b == '0);

  // One Booth step: add/subtract multiplicand by the bit pair, then arithmetic shift.
  always_comb begin
    m_ext = {b_m[WIDTH-1], b_m};
    case ({b_q[0], b_qm1})
      2'b01:   b_sum = b_acc + m_ext;
      2'b10:   b_sum = b_acc - m_ext;
      default: b_sum = b_acc;
    endcase
    b_acc_nxt = {b_sum[WIDTH], b_sum[WIDTH:1]};
    b_q_nxt   = {b_sum[0], b_q[WIDTH-1:1]};
  end

  // One restoring-division step plus the sign fix-up used on the last step.
  // The partial remainder always stays below the divisor, so WIDTH bits hold it.
  always_comb begin
    d_shift   = {d_rem, d_quo[WIDTH-1]};
    d_qbit    = (d_shift >= {1'b0, d_dvs});
    d_diff    = d_shift[WIDTH-1:0] - d_dvs;
    d_rem_nxt = d_qbit ? d_diff : d_shift[WIDTH-1:0];
    d_quo_nxt = {d_quo[WIDTH-2:0], d_qbit};
    d_quo_fix = neg_q ? -d_quo_nxt : d_quo_nxt;
    d_rem_fix = neg_r ? -d_rem_nxt : d_rem_nxt;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; starts are only honoured in IDLE, multiply has priority.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.mult_start)     state_nxt = S_MULT;
        else if (bus.div_start) state_nxt = b_is_zero ? S_DZERO : S_DIV;
      end
      S_MULT, S_DIV: begin
        if (abort_req)     state_nxt = S_IDLE;
        else if (cnt_last) state_nxt = S_DONE;
      end
      S_DONE, S_DZERO: state_nxt = S_IDLE;
      default:         state_nxt = S_IDLE;
    endcase
  end

  // Iteration counter, operand capture, per-cycle steps and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      b_acc <= '0;
      b_q   <= '0;
      b_qm1 <= 1'b0;
      b_m   <= '0;
      d_rem <= '0;
      d_quo <= '0;
      d_dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.mult_start) begin
            b_m   <= bus.op_a;
            b_q   <= bus.op_b;
            b_acc <= '0;
            b_qm1 <= 1'b0;
            cnt   <= CNT_W'(WIDTH - 1);
          end else if (bus.div_start && !b_is_zero) begin
            d_quo <= a_mag;
            d_dvs <= b_mag;
            d_rem <= '0;
            neg_q <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
            neg_r <= bus.op_a[WIDTH-1];
            cnt   <= CNT_W'(WIDTH - 1);
          end
        end
        S_MULT: begin
          if (!abort_req) begin
            b_acc <= b_acc_nxt;
            b_q   <= b_q_nxt;
            b_qm1 <= b_q[0];
            cnt   <= cnt - 1'b1;
            if (cnt_last) begin
              hi_q <= b_acc_nxt[WIDTH-1:0];
              lo_q <= b_q_nxt;
            end
          end
        end
        S_DIV: begin
          if (!abort_req) begin
            d_rem <= d_rem_nxt;
            d_quo <= d_quo_nxt;
            cnt   <= cnt - 1'b1;
            if (cnt_last) begin
              hi_q <= d_rem_fix;
              lo_q <= d_quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == S_MULT) || (state == S_DIV);
  assign bus.done     = (state == S_DONE) || (state == S_DZERO);
  assign bus.div_zero = (state == S_DZERO);
  assign bus.hi_write = (state == S_DONE);
  assign bus.lo_write = (state == S_DONE);
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: transaction-level timeline model plus
// literal expectations for the directed cases. MULDIV_ABORT_EN adds abort cases.
module tb_muldiv_ctrl;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;

  muldiv_ctrl_if #(.WIDTH(W)) bus ();

  muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Timeline model: how many busy cycles remain, whether this cycle is a
  // done / div-by-zero cycle, and the HI/LO values architecturally visible.
  int          busy_left;
  bit          done_now, dz_now;
  logic [31:0] res_hi, res_lo, exp_hi, exp_lo;
  longint      prod, qa, qb, quo, rem;

  always @(posedge clock or negedge reset) begin
    bit was_idle;
    if (!reset) begin
      busy_left = 0;
      done_now  = 0;
      dz_now    = 0;
      exp_hi    = '0;
      exp_lo    = '0;
    end else begin
      was_idle = (busy_left == 0) && !done_now && !dz_now;
      done_now = 0;
      dz_now   = 0;
      if (busy_left > 0) begin
`ifdef MULDIV_ABORT_EN
        if (bus.abort) busy_left = 0;
        else
`endif
        begin
          busy_left--;
          if (busy_left == 0) begin
            done_now = 1;
            exp_hi   = res_hi;
            exp_lo   = res_lo;
          end
        end
      end else if (was_idle) begin
        if (bus.mult_start) begin
          prod      = longint'($signed(bus.op_a)) * longint'($signed(bus.op_b));
          res_hi    = prod[63:32];
          res_lo    = prod[31:0];
          busy_left = W;
        end else if (bus.div_start) begin
          if (bus.op_b == 0) dz_now = 1;
          else begin
            qa        = longint'($signed(bus.op_a));
            qb        = longint'($signed(bus.op_b));
            quo       = qa / qb;
            rem       = qa % qb;
            res_hi    = rem[31:0];
            res_lo    = quo[31:0];
            busy_left = W;
          end
        end
      end
    end
  end

  // Compare process: all outputs against the model every cycle, away from the edge.
  always @(posedge clock) begin
    #2;
    if (chk_en) begin
      check("status", {59'd0, bus.busy, bus.done, bus.div_zero, bus.hi_write, bus.lo_write},
            {59'd0, (busy_left > 0), (done_now || dz_now), dz_now, done_now, done_now});
      check("hi_out", {32'd0, bus.hi_out}, {32'd0, exp_hi});
      check("lo_out", {32'd0, bus.lo_out}, {32'd0, exp_lo});
    end
  end

  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.mult_start = m;
    bus.div_start  = d;
    bus.op_a       = a;
    bus.op_b       = b;
    @(negedge clock);
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    bus.op_a       = $urandom;
    bus.op_b       = $urandom;
  endtask

  // Returns the cycle index (1 = cycle right after the start edge) of done.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!bus.done && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    if (!bus.done) check("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int cyc;
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
`ifdef MULDIV_ABORT_EN
    bus.abort      = 1'b0;
`endif
    bus.op_a       = '0;
    bus.op_b       = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    reset  = 1'b1;
    chk_en = 1'b1;

    // 7 * -3
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_done(cyc);
    check("mult_latency", 64'(cyc), 64'd33);
    check("mult_write", {62'd0, bus.hi_write, bus.lo_write}, 64'd3);
    check("mult_7x-3", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);

    // most-negative squared
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_done(cyc);
    check("mult_min_sq", {bus.hi_out, bus.lo_out}, 64'h4000_0000_0000_0000);

    // -7 / 2
    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    check("div_latency", 64'(cyc), 64'd33);
    check("div_-7/2", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);

    // divide by zero keeps prior HI/LO
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    wait_done(cyc);
    check("dz_latency", 64'(cyc), 64'd1);
    check("dz_flags", {61'd0, bus.div_zero, bus.hi_write, bus.lo_write}, 64'd4);
    check("dz_hilo_kept", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);

    // overflow wrap
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    check("div_wrap", {bus.hi_out, bus.lo_out}, 64'h0000_0000_8000_0000);

    // randomized operations, occasional double strobe and strobe during DONE
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [31:0] a, b;
      kind = $urandom_range(0, 3);
      a    = pick();
      b    = pick();
      start_op(kind == 0 || kind == 3, kind != 0, a, b);
      wait_done(cyc);
      if ($urandom_range(0, 1) == 1) begin
        bus.div_start = 1'b1;
        @(negedge clock);
        bus.div_start = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // mid-operation ignored start, then async reset abort
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (3) @(negedge clock);
    bus.div_start = 1'b1;
    @(negedge clock);
    bus.div_start = 1'b0;
    repeat (4) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("rst_busy", {62'd0, bus.busy, bus.done}, 64'd0);
    check("rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);

`ifdef MULDIV_ABORT_EN
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (11) @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check("abort_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    repeat (40) @(negedge clock);
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    wait_done(cyc);
    check("div_100/7", {bus.hi_out, bus.lo_out}, {32'd2, 32'd14});
`endif

    repeat (3) @(negedge clock);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
